// File: rtl/apb_pkg.sv
// Shared definitions for the APB master: FSM state encoding and default sizes.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int APB_ADDR_W_DEF  = 32;
  localparam int APB_DATA_W_DEF  = 32;
  localparam int APB_TIMEOUT_DEF = 255;

  // Bits needed to hold a count from 0 up to and including n.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/apb_master_if.sv
// APB bus bundle between one master and one slave.
interface apb_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_wdog.sv
// ACCESS-phase wait counter; expired is high once LIMIT wait cycles have elapsed.
module apb_wdog
  import apb_pkg::*;
#(
  parameter int LIMIT = APB_TIMEOUT_DEF
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int CW = cnt_width(LIMIT);

  logic [CW-1:0] count_reg;

  assign expired = (count_reg == CW'(LIMIT));

  // Holding at the limit keeps the count from wrapping if the abort is late.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (inc && !expired) begin
      count_reg <= count_reg + CW'(1);
    end
  end

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB master: CPU request -> SETUP -> ACCESS -> done pulse.
// Optional ACCESS timeout is enabled by defining APB_TIMEOUT_EN.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W_DEF,
  parameter int DATA_W      = APB_DATA_W_DEF,
  parameter int TIMEOUT_CYC = APB_TIMEOUT_DEF
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_busy,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  output logic              cpu_timeout,
  apb_master_if.master      apb
);

  apb_state_e        state_reg;
  logic              psel_reg;
  logic              penable_reg;
  logic              pwrite_reg;
  logic [ADDR_W-1:0] paddr_reg;
  logic [DATA_W-1:0] pwdata_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              err_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              access_ready;
  logic              access_abort;

  assign access_ready = (state_reg == ACCESS) && apb.PREADY;

`ifdef APB_TIMEOUT_EN
  logic timeout_reg;
  logic wdog_expired;

  apb_wdog #(
    .LIMIT(TIMEOUT_CYC)
  ) u_wdog (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .clear   (state_reg == SETUP),
    .inc     ((state_reg == ACCESS) && !apb.PREADY),
    .expired (wdog_expired)
  );

  // PREADY takes priority over an expiry landing on the same cycle.
  assign access_abort = (state_reg == ACCESS) && !apb.PREADY && wdog_expired;
  assign cpu_timeout  = timeout_reg;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYC < 0);
  assign access_abort       = 1'b0;
  assign cpu_timeout        = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_reg   <= IDLE;
      psel_reg    <= 1'b0;
      penable_reg <= 1'b0;
      pwrite_reg  <= 1'b0;
      paddr_reg   <= '0;
      pwdata_reg  <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      rdata_reg   <= '0;
`ifdef APB_TIMEOUT_EN
      timeout_reg <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cpu_req) begin
            state_reg  <= SETUP;
            psel_reg   <= 1'b1;
            busy_reg   <= 1'b1;
            pwrite_reg <= cpu_we;
            paddr_reg  <= cpu_addr;
            pwdata_reg <= cpu_wdata;
          end
        end
        SETUP: begin
          state_reg   <= ACCESS;
          penable_reg <= 1'b1;
        end
        ACCESS: begin
          if (access_ready) begin
            state_reg   <= IDLE;
            psel_reg    <= 1'b0;
            penable_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b1;
            err_reg     <= apb.PSLVERR;
            // An errored read still returns whatever the slave drove.
            if (!pwrite_reg) begin
              rdata_reg <= apb.PRDATA;
            end
`ifdef APB_TIMEOUT_EN
            timeout_reg <= 1'b0;
`endif
          end else if (access_abort) begin
            state_reg   <= IDLE;
            psel_reg    <= 1'b0;
            penable_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b1;
            err_reg     <= 1'b1;
`ifdef APB_TIMEOUT_EN
            timeout_reg <= 1'b1;
`endif
          end
        end
        default: begin
          state_reg   <= IDLE;
          psel_reg    <= 1'b0;
          penable_reg <= 1'b0;
          busy_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign apb.PSEL    = psel_reg;
  assign apb.PENABLE = penable_reg;
  assign apb.PWRITE  = pwrite_reg;
  assign apb.PADDR   = paddr_reg;
  assign apb.PWDATA  = pwdata_reg;

  assign cpu_busy  = busy_reg;
  assign cpu_done  = done_reg;
  assign cpu_err   = err_reg;
  assign cpu_rdata = rdata_reg;

endmodule

// File: tb/tb_apb_master.sv
// Directed self-checking bench for apb_master; the slave side is driven inline.
module tb_apb_master;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_busy;
  logic        cpu_done;
  logic [31:0] cpu_rdata;
  logic        cpu_err;
  logic        cpu_timeout;

  int checks = 0;
  int errors = 0;

  apb_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_master #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .TIMEOUT_CYC (4)
  ) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_busy    (cpu_busy),
    .cpu_done    (cpu_done),
    .cpu_rdata   (cpu_rdata),
    .cpu_err     (cpu_err),
    .cpu_timeout (cpu_timeout),
    .apb         (bus.master)
  );

  always #5 PCLK = ~PCLK;

  // {PSEL, PENABLE, cpu_busy, cpu_done}
  function automatic logic [3:0] ctl();
    return {bus.PSEL, bus.PENABLE, cpu_busy, cpu_done};
  endfunction

  // Presents a request before the next rising edge; leaves cpu_req high.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge PCLK);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
  endtask

  task automatic test_reset();
    #1 PRESETn = 1'b0;
    repeat (2) @(negedge PCLK);
    checks++; if ({bus.PSEL, bus.PENABLE, bus.PWRITE, cpu_busy, cpu_done, cpu_err, cpu_timeout} !== 7'b0)
      begin errors++; $display("FAIL rst_ctl got %b exp 0000000", {bus.PSEL, bus.PENABLE, bus.PWRITE, cpu_busy, cpu_done, cpu_err, cpu_timeout}); end
    checks++; if (bus.PADDR !== 32'h0) begin errors++; $display("FAIL rst_paddr got %h exp 0", bus.PADDR); end
    checks++; if (bus.PWDATA !== 32'h0) begin errors++; $display("FAIL rst_pwdata got %h exp 0", bus.PWDATA); end
    checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", cpu_rdata); end
    PRESETn = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_write();
    bus.PREADY = 1'b1; bus.PSLVERR = 1'b0;
    issue(1'b1, 32'h10, 32'hA5);
    @(negedge PCLK); cpu_req = 1'b0;
    checks++; if (ctl() !== 4'b1010) begin errors++; $display("FAIL wr_setup got %b exp 1010", ctl()); end
    checks++; if ({bus.PWRITE, bus.PADDR} !== {1'b1, 32'h10}) begin errors++; $display("FAIL wr_addr got %b/%h exp 1/00000010", bus.PWRITE, bus.PADDR); end
    @(negedge PCLK);
    checks++; if (ctl() !== 4'b1110) begin errors++; $display("FAIL wr_access got %b exp 1110", ctl()); end
    checks++; if (bus.PWDATA !== 32'hA5) begin errors++; $display("FAIL wr_pwdata got %h exp 000000a5", bus.PWDATA); end
    @(negedge PCLK);
    checks++; if (ctl() !== 4'b0001) begin errors++; $display("FAIL wr_done got %b exp 0001", ctl()); end
    checks++; if (cpu_err !== 1'b0) begin errors++; $display("FAIL wr_err got %b exp 0", cpu_err); end
    @(negedge PCLK);
    checks++; if (ctl() !== 4'b0000) begin errors++; $display("FAIL wr_idle got %b exp 0000", ctl()); end
    checks++; if ({bus.PADDR, bus.PWDATA, cpu_rdata} !== {32'h10, 32'hA5, 32'h0})
      begin errors++; $display("FAIL wr_hold got %h/%h/%h exp 00000010/000000a5/00000000", bus.PADDR, bus.PWDATA, cpu_rdata); end
    $display("test_write done");
  endtask

  task automatic test_read_wait();
    bus.PREADY = 1'b0; bus.PSLVERR = 1'b1; bus.PRDATA = 32'hDEAD;
    issue(1'b0, 32'h14, 32'h99);
    @(negedge PCLK); cpu_req = 1'b0;
    checks++; if (ctl() !== 4'b1010) begin errors++; $display("FAIL rd_setup got %b exp 1010", ctl()); end
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      checks++; if (ctl() !== 4'b1110) begin errors++; $display("FAIL rd_wait%0d got %b exp 1110", i, ctl()); end
      checks++; if ({bus.PWRITE, bus.PADDR} !== {1'b0, 32'h14}) begin errors++; $display("FAIL rd_paddr%0d got %b/%h exp 0/00000014", i, bus.PWRITE, bus.PADDR); end
    end
    bus.PREADY = 1'b1; bus.PSLVERR = 1'b0; bus.PRDATA = 32'h5A;
    @(negedge PCLK);
    bus.PRDATA = 32'h1111; bus.PSLVERR = 1'b1;
    checks++; if (ctl() !== 4'b0001) begin errors++; $display("FAIL rd_done got %b exp 0001", ctl()); end
    checks++; if ({cpu_rdata, cpu_err} !== {32'h5A, 1'b0}) begin errors++; $display("FAIL rd_data got %h/%b exp 0000005a/0", cpu_rdata, cpu_err); end
    @(negedge PCLK);
    checks++; if ({cpu_rdata, cpu_err} !== {32'h5A, 1'b0}) begin errors++; $display("FAIL rd_ignore got %h/%b exp 0000005a/0", cpu_rdata, cpu_err); end
    bus.PSLVERR = 1'b0;
    $display("test_read_wait done");
  endtask

  task automatic test_error();
    bus.PREADY = 1'b1; bus.PSLVERR = 1'b1;
    issue(1'b1, 32'h30, 32'h1234);
    @(negedge PCLK); cpu_req = 1'b0;
    repeat (2) @(negedge PCLK);
    checks++; if ({cpu_done, cpu_err} !== 2'b11) begin errors++; $display("FAIL err_wr got %b exp 11", {cpu_done, cpu_err}); end
    checks++; if (cpu_rdata !== 32'h5A) begin errors++; $display("FAIL err_wr_rdata got %h exp 0000005a", cpu_rdata); end
    bus.PSLVERR = 1'b0;
    @(negedge PCLK);
    checks++; if ({cpu_done, cpu_err} !== 2'b01) begin errors++; $display("FAIL err_hold got %b exp 01", {cpu_done, cpu_err}); end
    issue(1'b1, 32'h30, 32'h5678);
    @(negedge PCLK); cpu_req = 1'b0;
    repeat (2) @(negedge PCLK);
    checks++; if ({cpu_done, cpu_err} !== 2'b10) begin errors++; $display("FAIL err_clean got %b exp 10", {cpu_done, cpu_err}); end
    bus.PSLVERR = 1'b1; bus.PRDATA = 32'h77;
    issue(1'b0, 32'h34, 32'h0);
    @(negedge PCLK); cpu_req = 1'b0;
    repeat (2) @(negedge PCLK);
    checks++; if ({cpu_done, cpu_err, cpu_rdata} !== {2'b11, 32'h77}) begin errors++; $display("FAIL err_rd got %b/%h exp 11/00000077", {cpu_done, cpu_err}, cpu_rdata); end
    bus.PSLVERR = 1'b0;
    $display("test_error done");
  endtask

  task automatic test_back_to_back();
    bus.PREADY = 1'b1;
    issue(1'b1, 32'h20, 32'h1);
    @(negedge PCLK);
    cpu_addr = 32'h24; cpu_wdata = 32'h2;
    checks++; if (ctl() !== 4'b1010) begin errors++; $display("FAIL b2b_setup1 got %b exp 1010", ctl()); end
    @(negedge PCLK);
    checks++; if ({ctl(), bus.PADDR} !== {4'b1110, 32'h20}) begin errors++; $display("FAIL b2b_access1 got %b/%h exp 1110/00000020", ctl(), bus.PADDR); end
    @(negedge PCLK);
    checks++; if (ctl() !== 4'b0001) begin errors++; $display("FAIL b2b_done1 got %b exp 0001", ctl()); end
    @(negedge PCLK); cpu_req = 1'b0;
    checks++; if ({ctl(), bus.PADDR, bus.PWDATA} !== {4'b1010, 32'h24, 32'h2})
      begin errors++; $display("FAIL b2b_setup2 got %b/%h/%h exp 1010/00000024/00000002", ctl(), bus.PADDR, bus.PWDATA); end
    repeat (2) @(negedge PCLK);
    checks++; if (ctl() !== 4'b0001) begin errors++; $display("FAIL b2b_done2 got %b exp 0001", ctl()); end
    // A request pulsed during ACCESS must be dropped.
    bus.PREADY = 1'b0;
    issue(1'b1, 32'h40, 32'h3);
    @(negedge PCLK); cpu_req = 1'b0;
    @(negedge PCLK); cpu_req = 1'b1; cpu_addr = 32'h44;
    @(negedge PCLK); cpu_req = 1'b0; bus.PREADY = 1'b1;
    checks++; if (ctl() !== 4'b1110) begin errors++; $display("FAIL drop_access got %b exp 1110", ctl()); end
    @(negedge PCLK);
    checks++; if (ctl() !== 4'b0001) begin errors++; $display("FAIL drop_done got %b exp 0001", ctl()); end
    repeat (2) begin
      @(negedge PCLK);
      checks++; if ({ctl(), bus.PADDR} !== {4'b0000, 32'h40}) begin errors++; $display("FAIL drop_idle got %b/%h exp 0000/00000040", ctl(), bus.PADDR); end
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid();
    bus.PREADY = 1'b0;
    issue(1'b1, 32'h50, 32'h9);
    @(negedge PCLK); cpu_req = 1'b0;
    @(negedge PCLK);
    checks++; if (ctl() !== 4'b1110) begin errors++; $display("FAIL rmid_access got %b exp 1110", ctl()); end
    #2 PRESETn = 1'b0;
    #1;
    checks++; if ({ctl(), bus.PADDR} !== {4'b0000, 32'h0}) begin errors++; $display("FAIL rmid_async got %b/%h exp 0000/00000000", ctl(), bus.PADDR); end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h60; bus.PREADY = 1'b1;
    repeat (2) begin
      @(negedge PCLK);
      checks++; if (ctl() !== 4'b0000) begin errors++; $display("FAIL rmid_held got %b exp 0000", ctl()); end
    end
    PRESETn = 1'b1;
    @(negedge PCLK); cpu_req = 1'b0;
    checks++; if ({ctl(), bus.PADDR} !== {4'b1010, 32'h60}) begin errors++; $display("FAIL rmid_accept got %b/%h exp 1010/00000060", ctl(), bus.PADDR); end
    @(negedge PCLK); bus.PRDATA = 32'hC3;
    @(negedge PCLK);
    checks++; if ({ctl(), cpu_rdata} !== {4'b0001, 32'hC3}) begin errors++; $display("FAIL rmid_done got %b/%h exp 0001/000000c3", ctl(), cpu_rdata); end
    $display("test_reset_mid done");
  endtask

  task automatic test_timeout();
    bus.PREADY = 1'b0;
`ifdef APB_TIMEOUT_EN
    issue(1'b0, 32'h70, 32'h0);
    @(negedge PCLK); cpu_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge PCLK);
      checks++; if (ctl() !== 4'b1110) begin errors++; $display("FAIL to_wait%0d got %b exp 1110", i, ctl()); end
    end
    @(negedge PCLK);
    checks++; if ({ctl(), cpu_err, cpu_timeout} !== 6'b000111) begin errors++; $display("FAIL to_abort got %b exp 000111", {ctl(), cpu_err, cpu_timeout}); end
    @(negedge PCLK);
    checks++; if ({cpu_done, cpu_timeout} !== 2'b01) begin errors++; $display("FAIL to_hold got %b exp 01", {cpu_done, cpu_timeout}); end
    issue(1'b0, 32'h74, 32'h0);
    @(negedge PCLK); cpu_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge PCLK);
      checks++; if (ctl() !== 4'b1110) begin errors++; $display("FAIL to_race%0d got %b exp 1110", i, ctl()); end
    end
`else
    issue(1'b0, 32'h70, 32'h0);
    @(negedge PCLK); cpu_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK);
      checks++; if ({ctl(), cpu_timeout} !== 5'b11100) begin errors++; $display("FAIL nto_wait%0d got %b exp 11100", i, {ctl(), cpu_timeout}); end
    end
`endif
    bus.PREADY = 1'b1; bus.PRDATA = 32'h3C;
    @(negedge PCLK);
    checks++; if ({ctl(), cpu_err, cpu_timeout, cpu_rdata} !== {6'b000100, 32'h3C})
      begin errors++; $display("FAIL to_ready got %b/%h exp 000100/0000003c", {ctl(), cpu_err, cpu_timeout}, cpu_rdata); end
    $display("test_timeout done");
  endtask

  initial begin
    bus.PREADY = 1'b1; bus.PSLVERR = 1'b0; bus.PRDATA = '0;
    test_reset();
    test_write();
    test_read_wait();
    test_error();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter ADDR_W, default 32, APB address width.
REQ-002 Parameter DATA_W, default 32, APB data width.
REQ-003 Parameter TIMEOUT_CYC, default 255, max ACCESS wait cycles (used only with APB_TIMEOUT_EN).
REQ-004 PCLK  input  1  clock, all state on rising edge.
REQ-005 PRESETn  input  1  reset, asynchronous, active-low.
REQ-006 cpu_req  input  1  transfer request, sampled in IDLE only.
REQ-007 cpu_we  input  1  1=write, 0=read.
REQ-008 cpu_addr  input  ADDR_W  transfer address.
REQ-009 cpu_wdata  input  DATA_W  write data.
REQ-010 cpu_busy  output  1  high while the state is not IDLE.
REQ-011 cpu_done  output  1  one-cycle completion pulse.
REQ-012 cpu_rdata  output  DATA_W  last completed read data.
REQ-013 cpu_err  output  1  error status of last transfer, valid with cpu_done, held until next done.
REQ-014 cpu_timeout  output  1  last transfer aborted by timeout.
REQ-015 PSEL, PENABLE, PWRITE  output  1 each  APB control.
REQ-016 PADDR  output  ADDR_W; PWDATA  output  DATA_W  APB address/data.
REQ-017 PRDATA  input  DATA_W; PREADY, PSLVERR  input  1 each  APB slave response.

Function
REQ-018 FSM states IDLE, SETUP, ACCESS; state is registered; PSEL=(SETUP|ACCESS), PENABLE=ACCESS.
REQ-019 IDLE: cpu_req=1 registers cpu_we/addr/wdata into PWRITE/PADDR/PWDATA, next state SETUP.
REQ-020 SETUP lasts exactly one cycle, then ACCESS unconditionally.
REQ-021 ACCESS: PREADY=0 holds ACCESS; PREADY=1 goes to IDLE next cycle.
REQ-022 On the PREADY=1 ACCESS cycle: read captures PRDATA into cpu_rdata, cpu_err<=PSLVERR, cpu_timeout<=0, cpu_done pulses next cycle.
REQ-023 Writes leave cpu_rdata unchanged; an errored read still captures PRDATA.
REQ-024 PADDR, PWRITE, PWDATA stay constant from SETUP through the last ACCESS cycle and hold their values in IDLE.
REQ-025 Minimum latency: req sampled edge 0, SETUP cycle 1, ACCESS cycle 2, done high and IDLE cycle 3; new req is accepted in cycle 3.
REQ-026 cpu_req while busy is ignored (no queueing); the requester re-asserts after cpu_done.
REQ-027 PSLVERR and PRDATA are ignored outside ACCESS with PREADY=1.

Reset
REQ-028 PRESETn low immediately forces IDLE; PSEL, PENABLE, PWRITE, cpu_busy, cpu_done, cpu_err, cpu_timeout go to 0, and PADDR, PWDATA, cpu_rdata go to 0.
REQ-029 A reset during SETUP/ACCESS abandons the transfer with no cpu_done; first accept is possible on the first edge after release.

Configuration
REQ-030 Macro APB_TIMEOUT_EN defined: a counter clears on entering ACCESS and increments each ACCESS cycle with PREADY=0; when count==TIMEOUT_CYC with PREADY still 0, the transfer aborts to IDLE, and cpu_done=1, cpu_err=1, cpu_timeout=1 next cycle.
REQ-031 PREADY=1 on the same cycle the count reaches TIMEOUT_CYC completes normally (PREADY wins).
REQ-032 Macro undefined: no counter, ACCESS waits indefinitely, cpu_timeout tied 0.

Structure
REQ-033 Package apb_pkg holds the state enum (IDLE/SETUP/ACCESS) and default width/timeout constants.
REQ-034 Sub-module apb_wdog (timeout counter: clear, inc, expired) is instantiated only under APB_TIMEOUT_EN; everything else is inline.

Verification
REQ-035 Write addr 0x10, data 0xA5, PREADY tied 1 -> PSEL cycles 1-2, PENABLE cycle 2, PWDATA=0xA5, cpu_done cycle 3, cpu_err=0.
REQ-036 Read addr 0x14, PREADY low 3 ACCESS cycles, PRDATA=0x5A on the ready cycle -> cpu_rdata=0x5A, PADDR stable for all 4 ACCESS cycles.
REQ-037 Write with PSLVERR=1 on the ready cycle -> cpu_done with cpu_err=1; the next clean write returns cpu_err=0.
REQ-038 Back-to-back: cpu_req held high -> second SETUP starts in the cycle after the first cpu_done; a req pulsed during ACCESS is dropped.
REQ-039 PRESETn low mid-ACCESS -> PSEL/PENABLE 0 with no clock edge, no cpu_done.
REQ-040 APB_TIMEOUT_EN, TIMEOUT_CYC=4, PREADY stuck 0 -> abort after 4 wait cycles, cpu_done/cpu_err/cpu_timeout=1; PREADY=1 exactly at count 4 -> normal completion.
